// File: rtl/mem_lock_arbiter.sv
// rtl/mem_lock_arbiter.sv - age-ordered lock arbiter in front of a single-port word RAM
//
// Purpose: grants one requester at a time access to a shared data RAM. The
// oldest requester wins; age is measured as the modular distance of each
// requester's issue id from oldest_id. The winner gets one grant cycle. The
// read happens on the edge that enters GRANT, and a store happens on the edge
// that leaves GRANT.
//
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   req           - per-requester lock request
//   req_issue_id  - per-requester issue id, packed [i*ID_WIDTH +: ID_WIDTH]
//   release_lock  - per-requester lock release; must coincide with its grant
//   addr          - per-requester 30-bit word address, packed [i*30 +: 30]
//   wdata         - per-requester store data, packed [i*32 +: 32]
//   wen           - per-requester write enable
//   oldest_id     - issue id of the oldest in-flight instruction
//   mem_grant     - one-hot-or-zero grant, valid in GRANT while req is held
//   mem_rdata     - read data captured on entry to GRANT
//   protocol_err  - sticky release/grant mismatch flag
module mem_lock_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ID_WIDTH  = 4,
  parameter int MEM_WORDS = 1024
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*ID_WIDTH-1:0]  req_issue_id,
  input  logic [NUM_REQ-1:0]           release_lock,
  input  logic [NUM_REQ*30-1:0]        addr,
  input  logic [NUM_REQ*32-1:0]        wdata,
  input  logic [NUM_REQ-1:0]           wen,
  input  logic [ID_WIDTH-1:0]          oldest_id,
  output logic [NUM_REQ-1:0]           mem_grant,
  output logic [31:0]                  mem_rdata,
  output logic                         protocol_err
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int WW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0]          state;
  logic [WW-1:0]       winner;
  logic [WW-1:0]       sel_idx;
  logic                sel_valid;
  logic [ID_WIDTH-1:0] best_age;
  logic [ID_WIDTH-1:0] age;
  logic [AW-1:0]       rd_idx;
  logic [AW-1:0]       wr_idx;
  logic                grant_hit;
  logic                do_write;
  logic                proto_viol;

  logic [31:0] ram [MEM_WORDS];

  // Minimum modular age wins. The subtraction wraps in ID_WIDTH bits, so ids
  // that have rolled past zero still rank behind ids just below the wrap.
  // A strict less-than keeps the lowest index on a tie.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    best_age  = '0;
    age       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      age = req_issue_id[i*ID_WIDTH +: ID_WIDTH] - oldest_id;
      if (req[i] && (!sel_valid || age < best_age)) begin
        sel_valid = 1'b1;
        sel_idx   = WW'(i);
        best_age  = age;
      end
    end
  end

  // Only the low AW address bits index the RAM, so higher addresses alias.
  assign rd_idx = addr[sel_idx*30 +: AW];
  assign wr_idx = addr[winner*30 +: AW];

  // When the winner drops req during its GRANT cycle, the grant is aborted.
  assign grant_hit = (state == S_GRANT) && req[winner];
  assign do_write  = grant_hit && wen[winner];

  always_comb begin
    mem_grant = '0;
    if (grant_hit) mem_grant[winner] = 1'b1;
  end

  assign proto_viol = (|(release_lock & ~mem_grant)) | (|(mem_grant & ~release_lock));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      winner       <= '0;
      mem_rdata    <= '0;
      protocol_err <= 1'b0;
    end else begin
      protocol_err <= protocol_err | proto_viol;
      case (state)
        S_IDLE: begin
          if (sel_valid) begin
            winner    <= sel_idx;
            mem_rdata <= ram[rd_idx];
            state     <= S_GRANT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Reset forces state to IDLE asynchronously, which drops do_write. A reset
  // arriving mid-grant therefore never commits the store.
  always_ff @(posedge clk) begin
    if (do_write) ram[wr_idx] <= wdata[winner*32 +: 32];
  end

endmodule

// File: tb/tb_mem_lock_arbiter.sv
// tb/tb_mem_lock_arbiter.sv - directed self-checking bench for mem_lock_arbiter
module tb_mem_lock_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] req_issue_id;
  logic [3:0]  release_lock;
  logic [119:0] addr;
  logic [127:0] wdata;
  logic [3:0]  wen;
  logic [3:0]  oldest_id;
  logic [3:0]  mem_grant;
  logic [31:0] mem_rdata;
  logic        protocol_err;

  int checks   = 0;
  int failures = 0;

  mem_lock_arbiter #(.NUM_REQ(4), .ID_WIDTH(4), .MEM_WORDS(1024)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .req_issue_id (req_issue_id),
    .release_lock (release_lock),
    .addr         (addr),
    .wdata        (wdata),
    .wen          (wen),
    .oldest_id    (oldest_id),
    .mem_grant    (mem_grant),
    .mem_rdata    (mem_rdata),
    .protocol_err (protocol_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic r, input logic [3:0] id,
                       input logic [29:0] a, input logic [31:0] d, input logic w);
    req[i]                  = r;
    req_issue_id[i*4 +: 4]  = id;
    addr[i*30 +: 30]        = a;
    wdata[i*32 +: 32]       = d;
    wen[i]                  = w;
  endtask

  // One complete transaction from an idle arbiter: request, grant cycle with
  // release, then back to idle with the request dropped.
  task automatic single(input string tag, input int i, input logic [29:0] a,
                        input logic [31:0] d, input logic w,
                        input logic [31:0] exp_rd, input logic chk_rd);
    logic [3:0] onehot;
    onehot = 4'b0001 << i;
    drive(i, 1'b1, 4'd0, a, d, w);
    step();
    release_lock = onehot;
    #1;
    check({tag, "_grant"}, {28'd0, mem_grant}, {28'd0, onehot});
    if (chk_rd) check({tag, "_rdata"}, mem_rdata, exp_rd);
    step();
    drive(i, 1'b0, 4'd0, a, d, 1'b0);
    release_lock = 4'b0000;
    #1;
    check({tag, "_idle"}, {28'd0, mem_grant}, 32'd0);
  endtask

  // Two simultaneous requesters; expects grant to go to first, then second.
  task automatic pair(input string tag, input int first, input int second);
    logic [3:0] m1, m2;
    m1 = 4'b0001 << first;
    m2 = 4'b0001 << second;
    step();
    release_lock = m1;
    #1;
    check({tag, "_first"}, {28'd0, mem_grant}, {28'd0, m1});
    step();
    req[first]   = 1'b0;
    release_lock = 4'b0000;
    #1;
    check({tag, "_gap"}, {28'd0, mem_grant}, 32'd0);
    step();
    release_lock = m2;
    #1;
    check({tag, "_second"}, {28'd0, mem_grant}, {28'd0, m2});
    step();
    req[second]  = 1'b0;
    release_lock = 4'b0000;
    #1;
  endtask

  initial begin
    rst_n        = 1'b0;
    req          = '0;
    req_issue_id = '0;
    release_lock = '0;
    addr         = '0;
    wdata        = '0;
    wen          = '0;
    oldest_id    = '0;
    #12;
    check("rst_grant", {28'd0, mem_grant}, 32'd0);
    check("rst_rdata", mem_rdata, 32'd0);
    check("rst_perr", {31'd0, protocol_err}, 32'd0);
    step();
    rst_n = 1'b1;

    // Store, load, pre-write read data on a store, and address aliasing.
    single("st0", 0, 30'd5, 32'hDEADBEEF, 1'b1, 32'd0, 1'b0);
    single("ld1", 1, 30'd5, 32'd0, 1'b0, 32'hDEADBEEF, 1'b1);
    single("st2", 2, 30'd5, 32'h12345678, 1'b1, 32'hDEADBEEF, 1'b1);
    single("alias", 3, 30'd1029, 32'd0, 1'b0, 32'h12345678, 1'b1);

    // Age across wrap: oldest 14, id 15 (age 1) beats id 1 (age 3).
    oldest_id = 4'd14;
    drive(0, 1'b1, 4'd1, 30'd20, 32'd0, 1'b0);
    drive(2, 1'b1, 4'd15, 30'd21, 32'd0, 1'b0);
    pair("age", 2, 0);

    // Equal age: lowest index first.
    oldest_id = 4'd0;
    drive(1, 1'b1, 4'd3, 30'd22, 32'd0, 1'b0);
    drive(3, 1'b1, 4'd3, 30'd23, 32'd0, 1'b0);
    pair("tie", 1, 3);
    req_issue_id = '0;

    // Abort: the request is dropped in the GRANT cycle with wen still high.
    single("st7", 0, 30'd7, 32'hA5A5A5A5, 1'b1, 32'd0, 1'b0);
    drive(0, 1'b1, 4'd0, 30'd7, 32'hFFFFFFFF, 1'b1);
    step();
    req[0] = 1'b0;
    #1;
    check("abort_grant", {28'd0, mem_grant}, 32'd0);
    step();
    wen = '0;
    single("abort_ld", 1, 30'd7, 32'd0, 1'b0, 32'hA5A5A5A5, 1'b1);
    check("perr_clean", {31'd0, protocol_err}, 32'd0);

    // Release without a grant sets a sticky error.
    release_lock = 4'b0100;
    step();
    release_lock = 4'b0000;
    #1;
    check("perr_set", {31'd0, protocol_err}, 32'd1);
    step();
    step();
    check("perr_sticky", {31'd0, protocol_err}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("perr_rst", {31'd0, protocol_err}, 32'd0);
    step();
    rst_n = 1'b1;

    // Reset during a store grant: grant drops at once and nothing is written.
    drive(0, 1'b1, 4'd0, 30'd7, 32'h0BADF00D, 1'b1);
    step();
    release_lock = 4'b0001;
    #1;
    check("rstg_grant", {28'd0, mem_grant}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstg_drop", {28'd0, mem_grant}, 32'd0);
    check("rstg_rdata", mem_rdata, 32'd0);
    step();
    drive(0, 1'b0, 4'd0, 30'd7, 32'd0, 1'b0);
    release_lock = 4'b0000;
    rst_n = 1'b1;
    single("rstg_ld", 1, 30'd7, 32'd0, 1'b0, 32'hA5A5A5A5, 1'b1);
    check("perr_after", {31'd0, protocol_err}, 32'd0);

    // Grant without a matching release also flags an error.
    drive(3, 1'b1, 4'd0, 30'd9, 32'd0, 1'b0);
    step();
    #1;
    check("norel_grant", {28'd0, mem_grant}, 32'd8);
    step();
    drive(3, 1'b0, 4'd0, 30'd9, 32'd0, 1'b0);
    #1;
    check("norel_perr", {31'd0, protocol_err}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
